// File: rtl/mmio_timer_bank.sv
// mmio_timer_bank: memory-mapped bank of N_CH reload timers with per-channel
// interrupt enable/status, W1C status, one-shot mode and a global IRQ mask.
//
// Ports:
//   clk      in   system clock, all state on rising edge
//   reset    in   asynchronous active-high reset
//   rd       in   bus read strobe
//   wr       in   bus write strobe
//   addr     in   byte address (bits [1:0] ignored)
//   wdata    in   write data
//   rdata    out  read data, zero when not selected (OR-able with other slaves)
//   irq_vec  out  per-channel pending interrupt (STATUS & IRQEN)
//   irqout   out  aggregated interrupt gated by GIE
module mmio_timer_bank #(
    parameter int          N_CH      = 4,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h4000_1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd,
    input  logic            wr,
    input  logic [31:0]     addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [N_CH-1:0] irq_vec,
    output logic            irqout
);

    logic             win_hit;
    logic [7:0]       blk;
    logic [1:0]       reg_sel;
    logic             glb_hit;
    logic             gie_q;
    logic             gie_d;
    logic             unused_bits;

    logic [WIDTH-1:0] th_w   [N_CH];
    logic [WIDTH-1:0] tl_w   [N_CH];
    logic [3:0]       tcon_w [N_CH];

    // The 4 KB window is split into 16-byte blocks: one per channel,
    // then the global block directly after the last channel.
    assign win_hit     = (addr[31:12] == BASE_ADDR[31:12]);
    assign blk         = addr[11:4];
    assign reg_sel     = addr[3:2];
    assign glb_hit     = win_hit && (blk == 8'(N_CH));
    assign unused_bits = ^{addr[1:0], wdata};

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [WIDTH-1:0] th_q, th_d;
        logic [WIDTH-1:0] tl_q, tl_d;
        logic             en_q, en_d;
        logic             ie_q, ie_d;
        logic             st_q, st_d;
        logic             os_q, os_d;
        logic             sel;
        logic             ovf;

        assign sel = win_hit && (blk == 8'(c));
        assign ovf = en_q && (&tl_q);

        always_comb begin
            th_d = th_q;
            tl_d = tl_q;
            en_d = en_q;
            ie_d = ie_q;
            st_d = st_q;
            os_d = os_q;

            // Reload always uses the pre-edge TH.
            if (en_q) begin
                tl_d = ovf ? th_q : tl_q + WIDTH'(1);
            end
            if (ovf && os_q) begin
                en_d = 1'b0;
            end

            // Bus writes override counting and one-shot auto-clear.
            if (wr && sel) begin
                unique case (reg_sel)
                    2'd0: th_d = wdata[WIDTH-1:0];
                    2'd1: tl_d = wdata[WIDTH-1:0];
                    2'd2: begin
                        en_d = wdata[0];
                        ie_d = wdata[1];
                        os_d = wdata[3];
                        if (wdata[2]) begin
                            st_d = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            // A new overflow beats a same-edge W1C so no interrupt is lost.
            if (ovf && ie_q) begin
                st_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                th_q <= '0;
                tl_q <= '0;
                en_q <= 1'b0;
                ie_q <= 1'b0;
                st_q <= 1'b0;
                os_q <= 1'b0;
            end else begin
                th_q <= th_d;
                tl_q <= tl_d;
                en_q <= en_d;
                ie_q <= ie_d;
                st_q <= st_d;
                os_q <= os_d;
            end
        end

        assign th_w[c]   = th_q;
        assign tl_w[c]   = tl_q;
        assign tcon_w[c] = {os_q, st_q, ie_q, en_q};
        assign irq_vec[c] = st_q & ie_q;
    end

    always_comb begin
        gie_d = gie_q;
        if (wr && glb_hit && (reg_sel == 2'd0)) begin
            gie_d = wdata[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gie_q <= 1'b0;
        end else begin
            gie_q <= gie_d;
        end
    end

    assign irqout = gie_q & (|irq_vec);

    always_comb begin
        rdata = '0;
        if (rd && win_hit) begin
            for (int c = 0; c < N_CH; c++) begin
                if (blk == 8'(c)) begin
                    unique case (reg_sel)
                        2'd0:    rdata = 32'(th_w[c]);
                        2'd1:    rdata = 32'(tl_w[c]);
                        2'd2:    rdata = 32'(tcon_w[c]);
                        default: rdata = '0;
                    endcase
                end
            end
            if (glb_hit) begin
                unique case (reg_sel)
                    2'd0:    rdata = {31'd0, gie_q};
                    2'd1:    rdata = 32'(irq_vec);
                    default: rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmio_timer_bank.sv
// tb_mmio_timer_bank: directed scoreboard bench for mmio_timer_bank,
// a 4x32-bit instance plus a 2x8-bit instance sharing one bus.
module tb_mmio_timer_bank;

    localparam logic [31:0] A = 32'h4000_1000;
    localparam logic [31:0] B = 32'h4000_2000;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic [3:0]  irq_a;
    logic [1:0]  irq_b;
    logic        irqout_a;
    logic        irqout_b;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    mmio_timer_bank #(.N_CH(4), .WIDTH(32), .BASE_ADDR(A)) u_a (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata_a), .irq_vec(irq_a), .irqout(irqout_a)
    );

    mmio_timer_bank #(.N_CH(2), .WIDTH(8), .BASE_ADDR(B)) u_b (
        .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr),
        .wdata(wdata), .rdata(rdata_b), .irq_vec(irq_b), .irqout(irqout_b)
    );

    always #10 clk = ~clk;

    task automatic expect_v(input string tag, input logic [31:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_run++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h required an entry", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %h required %h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        step();
        wr    = 1'b0;
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] e,
                          input string tag);
        expect_v(tag, e);
        addr = a;
        rd   = 1'b1;
        #1;
        compare(rdata_a | rdata_b);
        rd   = 1'b0;
    endtask

    task automatic sig_chk(input logic [31:0] obs, input logic [31:0] e,
                           input string tag);
        expect_v(tag, e);
        compare(obs);
    endtask

    initial begin
        reset = 1'b1;
        rd    = 1'b0;
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
        step();
        step();
        rd_chk(A + 32'h08, 32'h0, "rst_tcon0");
        rd_chk(A + 32'h04, 32'h0, "rst_tl0");
        rd_chk(A + 32'h40, 32'h0, "rst_gctrl");
        sig_chk(32'(irqout_a), 32'h0, "rst_irqout");
        reset = 1'b0;
        step();

        // Reset while running with an interrupt pending.
        wr_reg(A + 32'h04, 32'hFFFF_FFFE);
        wr_reg(A + 32'h08, 32'h3);
        wr_reg(A + 32'h40, 32'h1);
        step();
        sig_chk(32'(irqout_a), 32'h1, "pre_rst_irq");
        reset = 1'b1;
        #1;
        sig_chk(32'(irqout_a), 32'h0, "async_rst_irqout");
        sig_chk(32'(irq_a), 32'h0, "async_rst_irqvec");
        rd_chk(A + 32'h04, 32'h0, "async_rst_tl0");
        rd_chk(A + 32'h08, 32'h0, "async_rst_tcon0");
        rd_chk(A + 32'h40, 32'h0, "async_rst_gctrl");
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            sig_chk(32'(irqout_a), 32'h0, "post_rst_irqout");
        end
        rd_chk(A + 32'h04, 32'h0, "post_rst_tl0");

        // Periodic reload on ch1.
        wr_reg(A + 32'h10, 32'hFFFF_FFFC);
        wr_reg(A + 32'h14, 32'hFFFF_FFFE);
        wr_reg(A + 32'h18, 32'h3);
        wr_reg(A + 32'h40, 32'h1);
        rd_chk(A + 32'h14, 32'hFFFF_FFFF, "per_tl_max");
        sig_chk(32'(irqout_a), 32'h0, "per_irq_pre");
        step();
        rd_chk(A + 32'h14, 32'hFFFF_FFFC, "per_tl_reload");
        rd_chk(A + 32'h18, 32'h7, "per_status");
        rd_chk(A + 32'h44, 32'h2, "per_gpend");
        sig_chk(32'(irqout_a), 32'h1, "per_irqout");

        wr_reg(A + 32'h18, 32'h7);
        rd_chk(A + 32'h18, 32'h3, "w1c_clear");
        rd_chk(A + 32'h14, 32'hFFFF_FFFD, "per_tl_count");
        sig_chk(32'(irqout_a), 32'h0, "w1c_irq_low");
        step();
        step();
        rd_chk(A + 32'h14, 32'hFFFF_FFFF, "per2_tl_max");
        rd_chk(A + 32'h18, 32'h3, "per2_no_status");
        step();
        rd_chk(A + 32'h14, 32'hFFFF_FFFC, "per2_tl_reload");
        rd_chk(A + 32'h18, 32'h7, "per2_status");

        // W1C on the same edge as a new overflow.
        step();
        step();
        step();
        rd_chk(A + 32'h14, 32'hFFFF_FFFF, "race_tl_max");
        wr_reg(A + 32'h18, 32'h7);
        rd_chk(A + 32'h18, 32'h7, "race_status_kept");
        rd_chk(A + 32'h14, 32'hFFFF_FFFC, "race_tl_reload");
        sig_chk(32'(irqout_a), 32'h1, "race_irq_high");
        wr_reg(A + 32'h18, 32'h7);
        rd_chk(A + 32'h18, 32'h3, "w1c_late_clear");
        sig_chk(32'(irqout_a), 32'h0, "w1c_late_irq_low");

        // TL write on the overflow edge.
        step();
        step();
        rd_chk(A + 32'h14, 32'hFFFF_FFFF, "coll_tl_max");
        wr_reg(A + 32'h14, 32'h0000_1234);
        rd_chk(A + 32'h14, 32'h0000_1234, "coll_tl_bus");
        rd_chk(A + 32'h18, 32'h7, "coll_status");
        step();
        rd_chk(A + 32'h14, 32'h0000_1235, "coll_tl_inc");
        wr_reg(A + 32'h18, 32'h4);
        rd_chk(A + 32'h18, 32'h0, "ch1_off");
        rd_chk(A + 32'h14, 32'h0000_1236, "ch1_off_tl");
        step();
        rd_chk(A + 32'h14, 32'h0000_1236, "ch1_frozen");

        // Masking and aggregation across ch0 and ch3.
        wr_reg(A + 32'h40, 32'h0);
        wr_reg(A + 32'h04, 32'hFFFF_FFFF);
        wr_reg(A + 32'h34, 32'hFFFF_FFFF);
        wr_reg(A + 32'h08, 32'h3);
        wr_reg(A + 32'h38, 32'h3);
        step();
        rd_chk(A + 32'h44, 32'h9, "mask_gpend");
        sig_chk(32'(irq_a), 32'h9, "mask_irqvec");
        sig_chk(32'(irqout_a), 32'h0, "mask_irqout");
        rd_chk(A + 32'h08, 32'h7, "mask_tcon0");
        wr_reg(A + 32'h40, 32'h1);
        sig_chk(32'(irqout_a), 32'h1, "gie_irqout");
        rd_chk(A + 32'h40, 32'h1, "gie_read");
        rd_chk(A + 32'h50, 32'h0, "unmapped_read");
        rd_chk(A + 32'h0C, 32'h0, "reserved_read");

        // One-shot on the 8-bit instance.
        wr_reg(B + 32'h00, 32'h1234_56F0);
        rd_chk(B + 32'h00, 32'h0000_00F0, "os_th_trunc");
        wr_reg(B + 32'h04, 32'h0000_00FE);
        wr_reg(B + 32'h08, 32'h0000_000B);
        step();
        rd_chk(B + 32'h04, 32'h0000_00FF, "os_tl_max");
        step();
        rd_chk(B + 32'h04, 32'h0000_00F0, "os_tl_reload");
        rd_chk(B + 32'h08, 32'h0000_000E, "os_tcon");
        sig_chk(32'(irq_b), 32'h1, "os_irqvec");
        sig_chk(32'(irqout_b), 32'h0, "os_irqout_masked");
        for (int i = 0; i < 20; i++) begin
            step();
            rd_chk(B + 32'h04, 32'h0000_00F0, "os_tl_frozen");
        end
        rd_chk(B + 32'h08, 32'h0000_000E, "os_tcon_final");

        if (exp_q.size() != 0) begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d required 0",
                   exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
